pb_debounce_bank: RTL and testbench

- Parametrised multi-channel pushbutton conditioner; successor to the per-button pb_debounce instances.
- Runs on the pixel clock clk_65M with an internal sample-tick prescaler, so no derived 250 Hz clock is needed.
- Per channel it provides:
  - synchronised, debounced level;
  - one-cycle press and release pulses;
  - optional hold-to-repeat pulses for jump, L and R auto-fire.
- Feeds vga_game directly.

---
 rtl/pb_debounce_bank.sv | 122 ++++++++++++
 tb/tb_pb_debounce_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce_bank.sv
// Multi-channel pushbutton conditioner: 2-FF sync, tick-sampled debounce, edge and hold-to-repeat pulses.
// Define PB_ACTIVE_LOW_EN to invert every pb_in bit ahead of the synchroniser for active-low boards.
module pb_debounce_bank #(
    parameter int N_CH         = 5,
    parameter int CLK_HZ       = 65000000,
    parameter int SAMPLE_HZ    = 250,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 125,
    parameter int REPEAT_RATE  = 25
) (
    input  logic            clk_65M,
    input  logic            clear,
    input  logic [N_CH-1:0] pb_in,
    input  logic [N_CH-1:0] rep_en,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic            sample_tick
);
    localparam int DIV    = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_W  = $clog2(DIV);
    localparam int HMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HCNT_W = $clog2(HMAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]        STAB_LAST = 4'(STABLE_CNT - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(REPEAT_DELAY - 1);
    // Reloading to DELAY-RATE makes later pulses land every RATE ticks.
    localparam logic [HCNT_W-1:0] HOLD_RELOAD =
        (REPEAT_DELAY > REPEAT_RATE) ? HCNT_W'(REPEAT_DELAY - REPEAT_RATE) : '0;

    logic [N_CH-1:0]             pb_raw;
    logic [N_CH-1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic                        tick_q, tick_d;
    logic [N_CH-1:0]             level_q, level_d;
    logic [N_CH-1:0]             press_q, press_d;
    logic [N_CH-1:0]             rel_q, rel_d;
    logic [N_CH-1:0]             rep_q, rep_d;
    logic [N_CH-1:0]             flip;
    logic [N_CH-1:0][3:0]        stab_q, stab_d;
    logic [N_CH-1:0][HCNT_W-1:0] hcnt_q, hcnt_d;

`ifdef PB_ACTIVE_LOW_EN
    assign pb_raw = ~pb_in;
`else
    assign pb_raw = pb_in;
`endif

    always_comb begin
        sync1_d = pb_raw;
        sync2_d = sync1_q;
        tick_d  = (div_q == DIV_LAST);
        div_d   = tick_d ? '0 : div_q + DIV_W'(1);
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        rep_d   = '0;
        flip    = '0;
        stab_d  = stab_q;
        hcnt_d  = hcnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (tick_q) begin
                if (sync2_q[i] == level_q[i]) begin
                    stab_d[i] = '0;
                end else if (stab_q[i] == STAB_LAST) begin
                    flip[i]    = 1'b1;
                    stab_d[i]  = '0;
                    level_d[i] = ~level_q[i];
                    press_d[i] = ~level_q[i];
                    rel_d[i]   = level_q[i];
                end else begin
                    stab_d[i] = stab_q[i] + 4'd1;
                end
            end
            // A press restarts the hold count; a release kills any pending repeat.
            if (!rep_en[i] || !level_q[i] || flip[i]) begin
                hcnt_d[i] = '0;
            end else if (tick_q) begin
                if (hcnt_q[i] == HOLD_LAST) begin
                    rep_d[i]  = 1'b1;
                    hcnt_d[i] = HOLD_RELOAD;
                end else begin
                    hcnt_d[i] = hcnt_q[i] + HCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_65M or negedge clear) begin
        if (!clear) begin
            sync1_q <= '0;
            sync2_q <= '0;
            div_q   <= '0;
            tick_q  <= 1'b0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            rep_q   <= '0;
            stab_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rep_q   <= rep_d;
            stab_q  <= stab_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign level_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign repeat_pulse  = rep_q;
    assign sample_tick   = tick_q;
endmodule

// File: tb/tb_pb_debounce_bank.sv
// Directed bench for pb_debounce_bank with DIV=10, STABLE_CNT=4, REPEAT_DELAY=5, REPEAT_RATE=2.
module tb_pb_debounce_bank;
    logic       clk_65M = 1'b0;
    logic       clear;
    logic [4:0] pb_in;
    logic [4:0] rep_en;
    logic [4:0] level_out, press_pulse, release_pulse, repeat_pulse;
    logic       sample_tick;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    pb_debounce_bank #(
        .N_CH(5), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_CNT(4),
        .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk_65M(clk_65M), .clear(clear), .pb_in(pb_in), .rep_en(rep_en),
        .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .sample_tick(sample_tick)
    );

    always #5 clk_65M = ~clk_65M;

    task automatic step();
        @(posedge clk_65M);
        cyc++;
        @(negedge clk_65M);
    endtask

    // Ticks are visible on cycles that are multiples of 10 after reset release.
    task automatic goto_tick();
        while (cyc % 10 != 0) step();
    endtask

    task automatic test_reset();
        int first_tick, bad_tick;
        clear = 1'b1; pb_in = '0; rep_en = '0;
        #1 clear = 1'b0;
        repeat (5) @(negedge clk_65M);
        total_cnt++;
        if (level_out !== 5'b0) $display("FAIL rst_level: got %b want 00000", level_out); else pass_cnt++;
        total_cnt++;
        if (press_pulse !== 5'b0) $display("FAIL rst_press: got %b want 00000", press_pulse); else pass_cnt++;
        total_cnt++;
        if (release_pulse !== 5'b0) $display("FAIL rst_release: got %b want 00000", release_pulse); else pass_cnt++;
        total_cnt++;
        if (repeat_pulse !== 5'b0) $display("FAIL rst_repeat: got %b want 00000", repeat_pulse); else pass_cnt++;
        total_cnt++;
        if (sample_tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", sample_tick); else pass_cnt++;
        clear = 1'b1;
        cyc = 0;
        first_tick = -1; bad_tick = 0;
        repeat (35) begin
            step();
            if (sample_tick === 1'b1 && first_tick < 0) first_tick = cyc;
            if (sample_tick !== ((cyc % 10) == 0)) bad_tick++;
        end
        total_cnt++;
        if (first_tick !== 10) $display("FAIL first_tick: got cycle %0d want 10", first_tick); else pass_cnt++;
        total_cnt++;
        if (bad_tick !== 0) $display("FAIL tick_period: %0d wrong cycles want 0", bad_tick); else pass_cnt++;
    endtask

    task automatic test_clean_press();
        int t0, first_p, n_p, first_r, n_r, n_rep;
        logic lvl40, lvl41;
        goto_tick(); t0 = cyc; pb_in[0] = 1'b1;
        first_p = -1; n_p = 0; n_r = 0; n_rep = 0; lvl40 = 1'bx; lvl41 = 1'bx;
        repeat (60) begin
            step();
            if (press_pulse[0]) begin n_p++; if (first_p < 0) first_p = cyc - t0; end
            if (release_pulse[0]) n_r++;
            if (repeat_pulse != 5'b0) n_rep++;
            if (cyc - t0 == 40) lvl40 = level_out[0];
            if (cyc - t0 == 41) lvl41 = level_out[0];
        end
        total_cnt++;
        if (first_p !== 41) $display("FAIL press_time: got +%0d want +41", first_p); else pass_cnt++;
        total_cnt++;
        if (n_p !== 1) $display("FAIL press_width: got %0d cycles want 1", n_p); else pass_cnt++;
        total_cnt++;
        if (lvl40 !== 1'b0 || lvl41 !== 1'b1)
            $display("FAIL press_level: got %b->%b want 0->1", lvl40, lvl41);
        else pass_cnt++;
        total_cnt++;
        if (n_r !== 0 || n_rep !== 0) $display("FAIL press_spurious: rel %0d rep %0d want 0 0", n_r, n_rep); else pass_cnt++;

        goto_tick(); t0 = cyc; pb_in[0] = 1'b0;
        first_r = -1; n_r = 0; n_p = 0;
        repeat (60) begin
            step();
            if (release_pulse[0]) begin n_r++; if (first_r < 0) first_r = cyc - t0; end
            if (press_pulse[0]) n_p++;
        end
        total_cnt++;
        if (first_r !== 41 || n_r !== 1)
            $display("FAIL release_pulse: got +%0d x%0d want +41 x1", first_r, n_r);
        else pass_cnt++;
        total_cnt++;
        if (level_out[0] !== 1'b0 || n_p !== 0)
            $display("FAIL release_level: got lvl %b press %0d want 0 0", level_out[0], n_p);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int t0, bad_l, bad_p, bad_r;
        goto_tick(); t0 = cyc; pb_in[1] = 1'b1;
        bad_l = 0; bad_p = 0; bad_r = 0;
        repeat (80) begin
            step();
            if (cyc - t0 == 30) pb_in[1] = 1'b0;
            if (level_out[1]) bad_l++;
            if (press_pulse[1]) bad_p++;
            if (release_pulse[1]) bad_r++;
        end
        total_cnt++;
        if (bad_l !== 0) $display("FAIL glitch_level: high %0d cycles want 0", bad_l); else pass_cnt++;
        total_cnt++;
        if (bad_p !== 0 || bad_r !== 0) $display("FAIL glitch_pulse: press %0d rel %0d want 0 0", bad_p, bad_r); else pass_cnt++;
    endtask

    task automatic test_repeat();
        int t0, first_p, n_rep, n_late, n_coinc;
        int rep_t[4];
        rep_en[2] = 1'b1;
        goto_tick(); t0 = cyc; pb_in[2] = 1'b1;
        first_p = -1; n_rep = 0; n_late = 0; n_coinc = 0;
        for (int k = 0; k < 4; k++) rep_t[k] = -1;
        repeat (135) begin
            step();
            if (press_pulse[2] && first_p < 0) first_p = cyc - t0;
            if ((press_pulse & repeat_pulse) != 5'b0) n_coinc++;
            if (repeat_pulse[2]) begin
                if (n_rep < 4) rep_t[n_rep] = cyc - t0;
                n_rep++;
            end
        end
        total_cnt++;
        if (first_p !== 41) $display("FAIL rep_press: got +%0d want +41", first_p); else pass_cnt++;
        total_cnt++;
        if (n_rep !== 3) $display("FAIL rep_count: got %0d want 3", n_rep); else pass_cnt++;
        total_cnt++;
        if (rep_t[0] !== 91 || rep_t[1] !== 111 || rep_t[2] !== 131)
            $display("FAIL rep_times: got +%0d +%0d +%0d want +91 +111 +131", rep_t[0], rep_t[1], rep_t[2]);
        else pass_cnt++;
        total_cnt++;
        if (n_coinc !== 0) $display("FAIL rep_coincide: got %0d want 0", n_coinc); else pass_cnt++;
        rep_en[2] = 1'b0;
        repeat (60) begin
            step();
            if (repeat_pulse[2]) n_late++;
        end
        total_cnt++;
        if (n_late !== 0 || level_out[2] !== 1'b1)
            $display("FAIL rep_disable: got %0d pulses lvl %b want 0 1", n_late, level_out[2]);
        else pass_cnt++;
        goto_tick(); pb_in[2] = 1'b0;
        repeat (60) step();
        total_cnt++;
        if (level_out[2] !== 1'b0) $display("FAIL rep_release: got %b want 0", level_out[2]); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int t0, pt, n, rt, nr, n_rep;
        logic [4:0] pv, rv;
        rep_en = '0;
        goto_tick(); t0 = cyc; pb_in = 5'b10101;
        pt = -1; n = 0; n_rep = 0; pv = '0;
        repeat (60) begin
            step();
            if (press_pulse != 5'b0) begin n++; pv = press_pulse; pt = cyc - t0; end
            if (repeat_pulse != 5'b0) n_rep++;
        end
        total_cnt++;
        if (pv !== 5'b10101 || pt !== 41 || n !== 1)
            $display("FAIL simul_press: got %b at +%0d x%0d want 10101 at +41 x1", pv, pt, n);
        else pass_cnt++;
        total_cnt++;
        if (level_out !== 5'b10101 || n_rep !== 0)
            $display("FAIL simul_level: got %b rep %0d want 10101 0", level_out, n_rep);
        else pass_cnt++;
        goto_tick(); t0 = cyc; pb_in = '0;
        rt = -1; nr = 0; rv = '0;
        repeat (60) begin
            step();
            if (release_pulse != 5'b0) begin nr++; rv = release_pulse; rt = cyc - t0; end
        end
        total_cnt++;
        if (rv !== 5'b10101 || rt !== 41 || nr !== 1 || level_out !== 5'b0)
            $display("FAIL simul_release: got %b at +%0d x%0d lvl %b want 10101 +41 x1 00000", rv, rt, nr, level_out);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int pt, rt;
        logic [4:0] pv, rv, rep_seen;
        rep_en = 5'b11111;
        goto_tick(); pb_in = 5'b11111;
        rep_seen = '0;
        repeat (100) begin
            step();
            rep_seen = rep_seen | repeat_pulse;
        end
        total_cnt++;
        if (level_out !== 5'b11111 || rep_seen !== 5'b11111)
            $display("FAIL ar_pre: got lvl %b rep %b want 11111 11111", level_out, rep_seen);
        else pass_cnt++;
        #2 clear = 1'b0;
        #1;
        total_cnt++;
        if ({level_out, press_pulse, release_pulse, repeat_pulse, sample_tick} !== 21'b0)
            $display("FAIL ar_clear: got lvl %b press %b rel %b rep %b tick %b want all 0",
                     level_out, press_pulse, release_pulse, repeat_pulse, sample_tick);
        else pass_cnt++;
        repeat (3) @(negedge clk_65M);
        clear = 1'b1;
        cyc = 0;
        pt = -1; rt = -1; pv = '0; rv = '0;
        repeat (95) begin
            step();
            if (press_pulse != 5'b0 && pt < 0) begin pt = cyc; pv = press_pulse; end
            if (repeat_pulse != 5'b0 && rt < 0) begin rt = cyc; rv = repeat_pulse; end
        end
        total_cnt++;
        if (pv !== 5'b11111 || pt !== 41)
            $display("FAIL ar_repress: got %b at %0d want 11111 at 41", pv, pt);
        else pass_cnt++;
        total_cnt++;
        if (rv !== 5'b11111 || rt !== 91)
            $display("FAIL ar_repeat: got %b at %0d want 11111 at 91", rv, rt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_repeat();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
